// File: rtl/alert_scheduler_pkg.sv
// Shared encodings, beep timing constants and helpers for the alert scheduler.
package alert_scheduler_pkg;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_ALARM = 2'd1;
  localparam logic [1:0] SRC_TIMER = 2'd2;
  localparam logic [1:0] SRC_CHIME = 2'd3;

  // The state encoding doubles as the src output, so src is just the state register.
  typedef enum logic [1:0] {
    ST_IDLE  = SRC_NONE,
    ST_ALARM = SRC_ALARM,
    ST_TIMER = SRC_TIMER,
    ST_CHIME = SRC_CHIME
  } state_e;

  localparam int LEN_W  = 4;
  localparam int BEEP_W = 4;

  localparam logic [LEN_W-1:0] ALARM_ON_TICKS  = LEN_W'(1);
  localparam logic [LEN_W-1:0] ALARM_OFF_TICKS = LEN_W'(1);
  localparam logic [LEN_W-1:0] TIMER_ON_TICKS  = LEN_W'(2);
  localparam logic [LEN_W-1:0] TIMER_OFF_TICKS = LEN_W'(2);
  localparam logic [LEN_W-1:0] CHIME_ON_TICKS  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CHIME_OFF_TICKS = LEN_W'(1);

  typedef struct packed {
    logic [LEN_W-1:0]  on_len;
    logic [LEN_W-1:0]  off_len;
    logic [BEEP_W-1:0] beeps;
    logic              endless;
  } beep_cfg_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/alert_scheduler_beep_pattern_gen.sv
// Beep pattern generator: on/off phases counted in tick_10hz, fixed or endless beep count.
module alert_scheduler_beep_pattern_gen
  import alert_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_rst,
  input  logic              run,
  input  logic              tick,
  input  logic [LEN_W-1:0]  on_len,
  input  logic [LEN_W-1:0]  off_len,
  input  logic [BEEP_W-1:0] beep_cnt,
  input  logic              endless,
  output logic              buzz,
  output logic              done_p
);

  logic              level_q, level_d;
  logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic [LEN_W-1:0]  cur_len;
  logic [LEN_W-1:0]  len_next;

  assign cur_len  = level_q ? on_len : off_len;
  assign len_next = len_cnt_q + LEN_W'(1);

  // Built from flops and the current config only, so the parent may steer state from it.
  assign done_p = tick & ~level_q & ~endless & (len_next >= off_len)
                & ((beep_q + BEEP_W'(1)) >= beep_cnt);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    level_d   = level_q;
    len_cnt_d = len_cnt_q;
    beep_d    = beep_q;
    if (phase_rst) begin
      level_d   = run;
      len_cnt_d = '0;
      beep_d    = '0;
    end else if (!run) begin
      level_d   = 1'b0;
      len_cnt_d = '0;
      beep_d    = '0;
    end else if (tick) begin
      if (len_next >= cur_len) begin
        len_cnt_d = '0;
        level_d   = ~level_q;
        if (!level_q && !endless && beep_q != '1) beep_d = beep_q + BEEP_W'(1);
      end else begin
        len_cnt_d = len_next;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      len_cnt_q <= '0;
      beep_q    <= '0;
    end else begin
      level_q   <= level_d;
      len_cnt_q <= len_cnt_d;
      beep_q    <= beep_d;
    end
  end

  assign buzz = level_q;

endmodule

// File: rtl/alert_scheduler.sv
// Shares the buzzer between alarm, timer expiry and hourly chime with snooze and auto-timeout.
module alert_scheduler
  import alert_scheduler_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int TIMER_BEEPS    = 4,
  parameter int CHIME_BEEPS    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_10hz,
  input  logic       tick_1hz,
  input  logic       alarm_ringing,
  input  logic       timer_done_p,
  input  logic       chime_p,
  input  logic       stop_p,
  input  logic       snooze_p,
  input  logic       clear_p,
  output logic       buzzer,
  output logic [1:0] src,
  output logic       alarm_stop_p,
  output logic       snooze_active
);

  localparam int SN_W = clog2(SNOOZE_S + 1);
  localparam int TO_W = clog2(RING_TIMEOUT_S + 1);

  state_e          state_q, state_d;
  logic            alarm_d1_q, alarm_d1_d;
  logic            alarm_stop_q, alarm_stop_d;
  logic            snooze_active_q, snooze_active_d;
  logic [SN_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic            timer_pend_q, timer_pend_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic            alarm_rise, snooze_fire, alarm_req, timeout;
  logic            beep_done;
  beep_cfg_t       cfg;

  assign alarm_rise  = alarm_ringing & ~alarm_d1_q;
  assign snooze_fire = snooze_active_q & ~clear_p
                     & ((snooze_cnt_q == '0) | (tick_1hz & (snooze_cnt_q == SN_W'(1))));
  assign alarm_req   = alarm_rise | snooze_fire;
  assign timeout     = (state_q == ST_ALARM) & tick_1hz
                     & (to_cnt_q == TO_W'(RING_TIMEOUT_S - 1));

  always_comb begin
    state_d         = state_q;
    alarm_d1_d      = alarm_ringing;
    alarm_stop_d    = 1'b0;
    snooze_active_d = snooze_active_q;
    snooze_cnt_d    = snooze_cnt_q;
    timer_pend_d    = timer_pend_q;
    to_cnt_d        = to_cnt_q;

    if (snooze_active_q && tick_1hz && snooze_cnt_q != '0) snooze_cnt_d = snooze_cnt_q - SN_W'(1);
    if (clear_p) begin
      snooze_active_d = 1'b0;
      timer_pend_d    = 1'b0;
    end
    if (state_q == ST_ALARM && tick_1hz && to_cnt_q != TO_W'(RING_TIMEOUT_S))
      to_cnt_d = to_cnt_q + TO_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (alarm_req) begin
          state_d = ST_ALARM;
          if (timer_done_p) timer_pend_d = 1'b1;
        end else if (timer_done_p || timer_pend_d) begin
          state_d      = ST_TIMER;
          timer_pend_d = 1'b0;
        end else if (chime_p) begin
          state_d = ST_CHIME;
        end
      end
      ST_ALARM: begin
        if (timer_done_p) timer_pend_d = 1'b1;
        if (stop_p) begin
          state_d         = ST_IDLE;
          alarm_stop_d    = 1'b1;
          snooze_active_d = 1'b0;
        end else if (snooze_p) begin
          state_d         = ST_IDLE;
          alarm_stop_d    = 1'b1;
          snooze_active_d = 1'b1;
          snooze_cnt_d    = SN_W'(SNOOZE_S);
        end else if (timeout) begin
          state_d      = ST_IDLE;
          alarm_stop_d = 1'b1;
        end
      end
      ST_TIMER: begin
        if (timer_done_p) timer_pend_d = 1'b1;
        if (alarm_req) begin
          state_d = ST_ALARM;
        end else if (stop_p) begin
          state_d      = ST_IDLE;
          timer_pend_d = 1'b0;
        end else if (beep_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHIME: begin
        if (alarm_req) begin
          state_d = ST_ALARM;
          if (timer_done_p) timer_pend_d = 1'b1;
        end else if (stop_p) begin
          state_d      = ST_IDLE;
          timer_pend_d = 1'b0;
        end else if (timer_done_p || timer_pend_d) begin
          state_d      = ST_TIMER;
          timer_pend_d = 1'b0;
        end else if (beep_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any ALARM entry restarts the timeout and supersedes a running snooze.
    if (state_d == ST_ALARM && state_q != ST_ALARM) begin
      to_cnt_d        = '0;
      snooze_active_d = 1'b0;
    end
  end

  always_comb begin
    cfg = '{on_len: ALARM_ON_TICKS, off_len: ALARM_OFF_TICKS, beeps: '0, endless: 1'b1};
    case (state_q)
      ST_TIMER: cfg = '{on_len: TIMER_ON_TICKS, off_len: TIMER_OFF_TICKS,
                        beeps: BEEP_W'(TIMER_BEEPS), endless: 1'b0};
      ST_CHIME: cfg = '{on_len: CHIME_ON_TICKS, off_len: CHIME_OFF_TICKS,
                        beeps: BEEP_W'(CHIME_BEEPS), endless: 1'b0};
      default:  cfg = '{on_len: ALARM_ON_TICKS, off_len: ALARM_OFF_TICKS,
                        beeps: '0, endless: 1'b1};
    endcase
  end

  // Pattern restarts on every state change; buzzer follows the next state so it is 1 on entry.
  alert_scheduler_beep_pattern_gen u_beep_pattern_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_rst (state_d != state_q),
    .run       (state_d != ST_IDLE),
    .tick      (tick_10hz),
    .on_len    (cfg.on_len),
    .off_len   (cfg.off_len),
    .beep_cnt  (cfg.beeps),
    .endless   (cfg.endless),
    .buzz      (buzzer),
    .done_p    (beep_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      alarm_d1_q      <= 1'b0;
      alarm_stop_q    <= 1'b0;
      snooze_active_q <= 1'b0;
      snooze_cnt_q    <= '0;
      timer_pend_q    <= 1'b0;
      to_cnt_q        <= '0;
    end else begin
      state_q         <= state_d;
      alarm_d1_q      <= alarm_d1_d;
      alarm_stop_q    <= alarm_stop_d;
      snooze_active_q <= snooze_active_d;
      snooze_cnt_q    <= snooze_cnt_d;
      timer_pend_q    <= timer_pend_d;
      to_cnt_q        <= to_cnt_d;
    end
  end

  assign src           = state_q;
  assign alarm_stop_p  = alarm_stop_q;
  assign snooze_active = snooze_active_q;

endmodule

// File: tb/tb_alert_scheduler.sv
// Directed bench for alert_scheduler: a vector table plus hand-written multi-cycle sequences.
module tb_alert_scheduler;

  typedef struct packed {
    logic t10, t1, ring, td, ch, st, sn, cl;
  } in_t;

  typedef struct packed {
    logic       buz;
    logic [1:0] src;
    logic       stp;
    logic       snz;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buzzer, alarm_stop_p, snooze_active;
  logic [1:0] src;
  in_t        cur;
  out_t       act;
  vec_t       vecs[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  assign act = {buzzer, src, alarm_stop_p, snooze_active};

  alert_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_10hz     (cur.t10),
    .tick_1hz      (cur.t1),
    .alarm_ringing (cur.ring),
    .timer_done_p  (cur.td),
    .chime_p       (cur.ch),
    .stop_p        (cur.st),
    .snooze_p      (cur.sn),
    .clear_p       (cur.cl),
    .buzzer        (buzzer),
    .src           (src),
    .alarm_stop_p  (alarm_stop_p),
    .snooze_active (snooze_active)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b (buz,src,stop,snz) expected %b", name, got[4:0], exp[4:0]);
    end
  endtask

  function automatic in_t mk(input logic t10, t1, ring, td, ch, st, sn, cl);
    return {t10, t1, ring, td, ch, st, sn, cl};
  endfunction

  function automatic out_t ex(input logic buz, input logic [1:0] s, input logic stp, snz);
    return {buz, s, stp, snz};
  endfunction

  task automatic add(input in_t i, input out_t e);
    vecs.push_back({i, e});
  endtask

  // Inputs are applied at a falling edge and outputs sampled at the next falling edge.
  task automatic step(input in_t v);
    cur = v;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cur   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", act, ex(0, 0, 0, 0));
    rst_n = 1'b1;
    step('0);
    check("post_reset_idle", act, ex(0, 0, 0, 0));

    // Alarm rise, 5 Hz toggling, stop with level held high (no retrigger).
    add(mk(0,0,1,0,0,0,0,0), ex(1, 1, 0, 0));
    add(mk(1,0,1,0,0,0,0,0), ex(0, 1, 0, 0));
    add(mk(1,0,1,0,0,0,0,0), ex(1, 1, 0, 0));
    add(mk(1,0,1,0,0,0,0,0), ex(0, 1, 0, 0));
    add(mk(1,0,1,0,0,0,0,0), ex(1, 1, 0, 0));
    add(mk(0,0,1,0,0,0,0,0), ex(1, 1, 0, 0));
    add(mk(0,0,1,0,0,1,0,0), ex(0, 0, 1, 0));
    add(mk(0,0,1,0,0,0,0,0), ex(0, 0, 0, 0));
    add(mk(0,0,0,0,0,0,0,0), ex(0, 0, 0, 0));
    // Chime: two 1-on/1-off beeps, exit after the last off tick.
    add(mk(0,0,0,0,1,0,0,0), ex(1, 3, 0, 0));
    add(mk(1,0,0,0,0,0,0,0), ex(0, 3, 0, 0));
    add(mk(1,0,0,0,0,0,0,0), ex(1, 3, 0, 0));
    add(mk(1,0,0,0,0,0,0,0), ex(0, 3, 0, 0));
    add(mk(1,0,0,0,0,0,0,0), ex(0, 0, 0, 0));
    add(mk(0,0,0,0,0,1,0,0), ex(0, 0, 0, 0));
    // Timer and chime together: timer wins, 4 beeps of 2 on / 2 off.
    add(mk(0,0,0,1,1,0,0,0), ex(1, 2, 0, 0));
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) add(mk(1,0,0,0,0,0,0,0), ex(0, 0, 0, 0));
      else         add(mk(1,0,0,0,0,0,0,0), ex((k % 4 == 0) || (k % 4 == 1), 2, 0, 0));
    end
    add(mk(0,0,0,0,0,0,0,0), ex(0, 0, 0, 0));
    add(mk(0,0,0,0,0,0,0,0), ex(0, 0, 0, 0));
    // Timer preempts a running chime; stop returns to idle.
    add(mk(0,0,0,0,1,0,0,0), ex(1, 3, 0, 0));
    add(mk(1,0,0,0,0,0,0,0), ex(0, 3, 0, 0));
    add(mk(0,0,0,1,0,0,0,0), ex(1, 2, 0, 0));
    add(mk(0,0,0,0,0,1,0,0), ex(0, 0, 0, 0));
    // Alarm preempts a running timer.
    add(mk(0,0,0,1,0,0,0,0), ex(1, 2, 0, 0));
    add(mk(1,0,0,0,0,0,0,0), ex(1, 2, 0, 0));
    add(mk(0,0,1,0,0,0,0,0), ex(1, 1, 0, 0));
    add(mk(0,0,1,0,0,1,0,0), ex(0, 0, 1, 0));
    add(mk(0,0,0,0,0,0,0,0), ex(0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Snooze, then re-ring after exactly SNOOZE_S seconds with ringing low.
    step(mk(0,0,1,0,0,0,0,0));
    check("snz_enter", act, ex(1, 1, 0, 0));
    step(mk(0,0,1,0,0,0,1,0));
    check("snz_stop_pulse", act, ex(0, 0, 1, 1));
    step(mk(0,0,0,0,0,0,0,0));
    check("snz_pulse_one_cycle", act, ex(0, 0, 0, 1));
    repeat (299) step(mk(0,1,0,0,0,0,0,0));
    check("snz_299_ticks", act, ex(0, 0, 0, 1));
    step(mk(0,1,0,0,0,0,0,0));
    check("snz_rering", act, ex(1, 1, 0, 0));
    step(mk(0,0,0,0,0,0,0,0));
    check("snz_rering_hold", act, ex(1, 1, 0, 0));
    // Snooze again, then clear_p cancels it: no re-ring.
    step(mk(0,0,0,0,0,0,1,0));
    check("snz_again", act, ex(0, 0, 1, 1));
    repeat (10) step(mk(0,1,0,0,0,0,0,0));
    step(mk(0,0,0,0,0,0,0,1));
    check("snz_clear", act, ex(0, 0, 0, 0));
    repeat (300) step(mk(0,1,0,0,0,0,0,0));
    check("snz_cleared_no_rering", act, ex(0, 0, 0, 0));

    // Auto-timeout after RING_TIMEOUT_S seconds; snooze not armed.
    step(mk(0,0,1,0,0,0,0,0));
    check("to_enter", act, ex(1, 1, 0, 0));
    repeat (59) step(mk(0,1,1,0,0,0,0,0));
    check("to_59s", act, ex(1, 1, 0, 0));
    step(mk(0,1,1,0,0,0,0,0));
    check("to_fire", act, ex(0, 0, 1, 0));
    step(mk(0,0,1,0,0,0,0,0));
    check("to_after", act, ex(0, 0, 0, 0));
    step(mk(0,0,0,0,0,0,0,0));

    // Timer during alarm is held and served once the alarm is stopped.
    step(mk(0,0,1,0,0,0,0,0));
    step(mk(0,0,1,1,0,0,0,0));
    check("pend_in_alarm", act, ex(1, 1, 0, 0));
    step(mk(0,0,1,0,0,1,0,0));
    check("pend_alarm_stop", act, ex(0, 0, 1, 0));
    step(mk(0,0,1,0,0,0,0,0));
    check("pend_serviced", act, ex(1, 2, 0, 0));
    step(mk(1,0,1,0,0,0,0,0));
    check("pend_tick1", act, ex(1, 2, 0, 0));
    step(mk(1,0,1,0,0,0,0,0));
    check("pend_tick2", act, ex(0, 2, 0, 0));
    step(mk(0,0,0,0,0,1,0,0));
    check("pend_timer_stop", act, ex(0, 0, 0, 0));

    // clear_p drops a pending timer.
    step(mk(0,0,1,0,0,0,0,0));
    step(mk(0,0,1,1,0,0,0,0));
    step(mk(0,0,1,0,0,0,0,1));
    check("clr_alarm_continues", act, ex(1, 1, 0, 0));
    step(mk(0,0,1,0,0,1,0,0));
    step(mk(0,0,0,0,0,0,0,0));
    check("clr_no_timer", act, ex(0, 0, 0, 0));

    // Asynchronous reset mid-chime.
    step(mk(0,0,0,0,1,0,0,0));
    step(mk(1,0,0,0,0,0,0,0));
    step(mk(1,0,0,0,0,0,0,0));
    cur = '0;
    @(posedge clk);
    #3;
    check("chime_before_rst", act, ex(1, 3, 0, 0));
    rst_n = 1'b0;
    #1;
    check("async_rst", act, ex(0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step('0);
    step('0);
    check("after_rst_idle", act, ex(0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
